if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the ID stage and its controller.
- Owns the PC register and the instruction-memory request/ack handshake. Drives the IF/ID pipeline register.
- Applies the controller's pc_src redirect and if_en stall.
- Holds one skid entry so that a fetch completing during a stall is not lost.
- Squashes wrong-path fetches on redirect. No branch delay slot.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_NEXT, 2'd0, pc_src encoding: sequential.
PC_JUMP, 2'd1, pc_src encoding: J/JAL target.
PC_JR, 2'd2, pc_src encoding: register target.
PC_BRANCH, 2'd3, pc_src encoding: taken BEQ/BNE.

Ports:
clk  in  1  main clock
rst  in  1  synchronous reset, active-high
if_en  in  1  from controller; 0 = ID stalled, hold the IF/ID register
pc_src  in  2  from controller, decoded from the instruction in ID
jr_target  in  32  forwarded rs value used for PC_JR
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, word aligned
imem_ack  in  1  rdata valid this cycle; completes the request
imem_rdata  in  32  fetched instruction
id_inst  out  32  IF/ID instruction register
id_pc  out  32  IF/ID PC of that instruction
id_pc_plus4  out  32  IF/ID PC+4
id_valid  out  1  IF/ID valid flag
fetch_busy  out  1  1 while no valid instruction is available to load into ID (state FETCH without ack, or DRAIN)

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc=RESET_PC, state=FETCH.
  - id_valid=0, id_inst=0, id_pc=0, id_pc_plus4=0.
  - skid cleared, pc_pending=0.
  - imem_req forced to 0 while rst is high. The first request is issued in the first cycle after rst falls.
  - Reset mid-request abandons it. Any later ack is ignored in that cycle.
- Handshake: while imem_req=1 with no ack, imem_addr is held stable. The transfer completes on the cycle imem_ack=1. Memory latency is 0..N cycles.
- Redirect: redirect = id_valid & if_en & (pc_src != PC_NEXT). The target is:
  - PC_JUMP: {id_pc_plus4[31:28], id_inst[25:0], 2'b00}
  - PC_JR: jr_target
  - PC_BRANCH: id_pc_plus4 + {{14{id_inst[15]}}, id_inst[15:0], 2'b00}, with 32-bit wrap.
- Whenever redirect=1, the IF/ID register loads a bubble (id_valid<=0). This squashes the wrong-path instruction.
- State FETCH (imem_req=1, imem_addr=pc):
  - redirect & ack: discard rdata, pc<=target, stay in FETCH.
  - redirect & !ack: pc_pending<=target, go to DRAIN.
  - ack & if_en: id_inst<=rdata, id_pc<=pc, id_pc_plus4<=pc+4, id_valid<=1, pc<=pc+4.
  - ack & !if_en: skid<=(rdata, pc), pc<=pc+4, go to HOLD. The IF/ID register holds.
  - !ack & if_en: id_valid<=0 (bubble).
  - !ack & !if_en: hold everything.
- State HOLD (imem_req=0):
  - redirect: drop skid, pc<=target, go to FETCH.
  - else if_en: IF/ID<=skid with id_valid=1, go to FETCH.
  - else: hold.
- State DRAIN (imem_req=1, imem_addr=the old pc, held):
  - Any rdata returned is discarded.
  - if_en loads a bubble.
  - A further redirect overwrites pc_pending (latest wins).
  - On ack: pc<=pc_pending (or the new target if a redirect occurs in the same cycle), go to FETCH.
- if_en=0 never changes id_* outputs, except under rst.
- pc+4 wraps modulo 2^32.
- imem_addr[1:0] is always 2'b00. A misaligned jr_target is passed with its low bits forced to 0.

Test Plan:
1. Reset, then imem_ack tied to 1 with rdata=addr: imem_addr sequence 0,4,8,C. id_valid rises 1 cycle after the first req and id_pc follows 0,4,8.
2. Ack delayed 3 cycles at pc=8: imem_addr stays 8 for 4 cycles; id_valid=0 for 3 cycles; fetch_busy=1 during the wait; then id_pc=8.
3. if_en=0 for 2 cycles while ack arrives for pc=C: imem_req drops during HOLD and id_* hold. When if_en=1, id_pc=C loads from skid and the next req is addr 10.
4. BEQ in ID at id_pc=20 with imm=16'hFFFC, pc_src=3, ack same cycle: id_valid=0 next cycle; the next imem_addr=14; the fetch of 24 is discarded.
5. JR (pc_src=2, jr_target=0x100) while the fetch for 44 is pending with no ack: DRAIN holds addr 44. On ack, rdata is discarded and the next req addr is 100.
6. rst asserted during DRAIN: next cycle imem_req=0 and id_valid=0. After rst falls, imem_addr=RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, the imem request/ack handshake and the IF/ID register.
// A one-entry skid keeps a fetch that completes during an ID stall; redirects squash wrong-path fetches.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [1:0]  PC_NEXT   = 2'd0,
  parameter logic [1:0]  PC_JUMP   = 2'd1,
  parameter logic [1:0]  PC_JR     = 2'd2,
  parameter logic [1:0]  PC_BRANCH = 2'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_en,
  input  logic [1:0]  pc_src,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        fetch_busy
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pc_pending;
  logic [31:0] skid_inst;
  logic [31:0] skid_pc;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc + 32'd4;
  assign redirect = id_valid & if_en & (pc_src != PC_NEXT);

  always_comb begin
    target = id_pc_plus4;
    if (pc_src == PC_JUMP) begin
      target = {id_pc_plus4[31:28], id_inst[25:0], 2'b00};
    end else if (pc_src == PC_JR) begin
      target = jr_target;
    end else if (pc_src == PC_BRANCH) begin
      target = id_pc_plus4 + {{14{id_inst[15]}}, id_inst[15:0], 2'b00};
    end
    // Misaligned register targets are truncated to the containing word.
    target[1:0] = 2'b00;
  end

  // In DRAIN the old address stays on the bus until the outstanding fetch is acked.
  assign imem_req   = ~rst & (state != ST_HOLD);
  assign imem_addr  = {pc[31:2], 2'b00};
  assign fetch_busy = ((state == ST_FETCH) & ~imem_ack) | (state == ST_DRAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      pc_pending  <= 32'd0;
      skid_inst   <= 32'd0;
      skid_pc     <= 32'd0;
      id_inst     <= 32'd0;
      id_pc       <= 32'd0;
      id_pc_plus4 <= 32'd0;
      id_valid    <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (redirect) begin
            id_valid <= 1'b0;
            if (imem_ack) begin
              pc <= target;
            end else begin
              pc_pending <= target;
              state      <= ST_DRAIN;
            end
          end else if (imem_ack) begin
            pc <= pc_plus4;
            if (if_en) begin
              id_inst     <= imem_rdata;
              id_pc       <= pc;
              id_pc_plus4 <= pc_plus4;
              id_valid    <= 1'b1;
            end else begin
              skid_inst <= imem_rdata;
              skid_pc   <= pc;
              state     <= ST_HOLD;
            end
          end else if (if_en) begin
            id_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            id_valid <= 1'b0;
            pc       <= target;
            state    <= ST_FETCH;
          end else if (if_en) begin
            id_inst     <= skid_inst;
            id_pc       <= skid_pc;
            id_pc_plus4 <= skid_pc + 32'd4;
            id_valid    <= 1'b1;
            state       <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (if_en) begin
            id_valid <= 1'b0;
          end
          if (redirect) begin
            pc_pending <= target;
          end
          if (imem_ack) begin
            pc    <= redirect ? target : pc_pending;
            state <= ST_FETCH;
          end
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: sequential fetch, slow ack, stall/skid, branch, JR drain, reset.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_en;
  logic [1:0]  pc_src;
  logic [31:0] jr_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        fetch_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Memory image: each word holds its address, except a BEQ with offset -4 words at 0x20.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h20) ? 32'h1000_FFFC : a;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  if_fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .if_en      (if_en),
    .pc_src     (pc_src),
    .jr_target  (jr_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
    .id_pc_plus4(id_pc_plus4),
    .id_valid   (id_valid),
    .fetch_busy (fetch_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs are then applied 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; if_en = 1'b1; pc_src = 2'd0; jr_target = 32'd0; imem_ack = 1'b0;
    tick();
    tick();
    settle();
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_valid", {31'd0, id_valid}, 32'd0);
    check_eq("rst_id_pc", id_pc, 32'd0);
    check_eq("rst_id_inst", id_inst, 32'd0);

    // 1: zero-latency sequential fetch
    rst = 1'b0; imem_ack = 1'b1;
    settle();
    check_eq("t1_req", {31'd0, imem_req}, 32'd1);
    check_eq("t1_addr0", imem_addr, 32'h0);
    tick(); settle();
    check_eq("t1_addr4", imem_addr, 32'h4);
    check_eq("t1_valid", {31'd0, id_valid}, 32'd1);
    check_eq("t1_id_pc0", id_pc, 32'h0);
    check_eq("t1_pc4", id_pc_plus4, 32'h4);
    tick(); settle();
    check_eq("t1_addr8", imem_addr, 32'h8);
    check_eq("t1_id_pc4", id_pc, 32'h4);

    // 2: ack delayed three cycles at pc=8
    imem_ack = 1'b0;
    settle();
    check_eq("t2_busy", {31'd0, fetch_busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      check_eq("t2_addr_hold", imem_addr, 32'h8);
      check_eq("t2_bubble", {31'd0, id_valid}, 32'd0);
      check_eq("t2_busy_wait", {31'd0, fetch_busy}, 32'd1);
    end
    imem_ack = 1'b1;
    settle();
    check_eq("t2_not_busy", {31'd0, fetch_busy}, 32'd0);
    tick(); settle();
    check_eq("t2_id_pc8", id_pc, 32'h8);
    check_eq("t2_valid", {31'd0, id_valid}, 32'd1);
    check_eq("t2_addrC", imem_addr, 32'hC);

    // 3: stall while the fetch of 0xC completes -> skid
    if_en = 1'b0;
    tick(); settle();
    imem_ack = 1'b0;
    check_eq("t3_req_hold", {31'd0, imem_req}, 32'd0);
    check_eq("t3_id_pc_held", id_pc, 32'h8);
    check_eq("t3_busy_hold", {31'd0, fetch_busy}, 32'd0);
    tick(); settle();
    check_eq("t3_req_hold2", {31'd0, imem_req}, 32'd0);
    check_eq("t3_id_pc_held2", id_pc, 32'h8);
    check_eq("t3_valid_held", {31'd0, id_valid}, 32'd1);
    if_en = 1'b1;
    tick(); settle();
    check_eq("t3_id_pc_skid", id_pc, 32'hC);
    check_eq("t3_id_inst_skid", id_inst, 32'hC);
    check_eq("t3_valid_skid", {31'd0, id_valid}, 32'd1);
    check_eq("t3_addr10", imem_addr, 32'h10);
    check_eq("t3_req", {31'd0, imem_req}, 32'd1);

    // 4: BEQ at 0x20, offset 0xFFFC -> target 0x14
    imem_ack = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    settle();
    check_eq("t4_id_pc20", id_pc, 32'h20);
    check_eq("t4_id_inst", id_inst, 32'h1000_FFFC);
    check_eq("t4_addr24", imem_addr, 32'h24);
    pc_src = 2'd3;
    tick();
    pc_src = 2'd0;
    settle();
    check_eq("t4_squash", {31'd0, id_valid}, 32'd0);
    check_eq("t4_addr14", imem_addr, 32'h14);
    tick(); settle();
    check_eq("t4_id_pc14", id_pc, 32'h14);

    // 5: JR to 0x100 (misaligned 0x103) while fetch of 0x44 is outstanding
    for (int i = 0; i < 11; i++) tick();
    settle();
    check_eq("t5_addr44", imem_addr, 32'h44);
    check_eq("t5_id_pc40", id_pc, 32'h40);
    imem_ack = 1'b0; pc_src = 2'd2; jr_target = 32'h103;
    tick();
    pc_src = 2'd0;
    settle();
    check_eq("t5_drain_addr", imem_addr, 32'h44);
    check_eq("t5_drain_req", {31'd0, imem_req}, 32'd1);
    check_eq("t5_drain_busy", {31'd0, fetch_busy}, 32'd1);
    check_eq("t5_drain_bubble", {31'd0, id_valid}, 32'd0);
    tick(); settle();
    check_eq("t5_drain_addr2", imem_addr, 32'h44);
    imem_ack = 1'b1;
    tick(); settle();
    check_eq("t5_discard", {31'd0, id_valid}, 32'd0);
    check_eq("t5_addr100", imem_addr, 32'h100);
    tick(); settle();
    check_eq("t5_id_pc100", id_pc, 32'h100);
    check_eq("t5_valid100", {31'd0, id_valid}, 32'd1);

    // 6: J (target 0x400) into DRAIN, then reset mid-request with a stray ack
    imem_ack = 1'b0; pc_src = 2'd1;
    tick();
    pc_src = 2'd0;
    settle();
    check_eq("t6_drain_addr", imem_addr, 32'h104);
    rst = 1'b1; imem_ack = 1'b1;
    settle();
    check_eq("t6_req_in_rst", {31'd0, imem_req}, 32'd0);
    tick(); settle();
    check_eq("t6_req_after_rst", {31'd0, imem_req}, 32'd0);
    check_eq("t6_valid_rst", {31'd0, id_valid}, 32'd0);
    check_eq("t6_id_pc_rst", id_pc, 32'd0);
    rst = 1'b0;
    settle();
    check_eq("t6_addr_reset_pc", imem_addr, 32'h0);
    check_eq("t6_req_reset", {31'd0, imem_req}, 32'd1);
    tick(); settle();
    check_eq("t6_id_pc0", id_pc, 32'h0);
    check_eq("t6_addr4", imem_addr, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
